// File: rtl/seven_segment_counter_mux_if.sv
// Control and display bus of the multiplexed seven-segment BCD counter.
// The master side drives the controls; the slave side (the counter) drives the display outputs.
interface seven_segment_counter_mux_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      ena;
    logic                      count_en;
    logic                      up;
    logic                      clear;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_bcd;
    logic [4*NUM_DIGITS-1:0]   bcd_out;
    logic [6:0]                segments;
    logic [NUM_DIGITS-1:0]     digit_sel;
    logic                      tick;
    logic                      wrap;

    modport master (
        output ena, count_en, up, clear, load, load_bcd,
        input  bcd_out, segments, digit_sel, tick, wrap
    );

    modport slave (
        input  ena, count_en, up, clear, load, load_bcd,
        output bcd_out, segments, digit_sel, tick, wrap
    );
endinterface

// File: rtl/seven_segment_counter_mux.sv
// Multi-digit BCD up/down counter with a tick prescaler and a time-multiplexed
// seven-segment scan (one-hot digit select, shared segment bus, optional leading-zero blanking).
module seven_segment_counter_mux #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_COUNT = 1000,
    parameter int unsigned SCAN_COUNT = 4,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    seven_segment_counter_mux_if.slave bus
);
    localparam int unsigned BW = 4 * NUM_DIGITS;
    localparam int unsigned PW = $clog2(TICK_COUNT);
    localparam int unsigned SW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_COUNT - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_COUNT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_ZERO  = 7'h3F;

    // Segment bit 0 = a ... bit 6 = g, active-high.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [PW-1:0]         pre_q,       pre_d;
    logic [BW-1:0]         bcd_q,       bcd_d;
    logic [SW-1:0]         scan_cnt_q,  scan_cnt_d;
    logic [IW-1:0]         scan_idx_q,  scan_idx_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [6:0]            segments_q,  segments_d;
    logic                  tick_q,      tick_d;
    logic                  wrap_q,      wrap_d;

    logic [BW-1:0]         bcd_step;
    logic                  step_wrap;
    logic [BW-1:0]         bcd_clamped;
    logic [NUM_DIGITS-1:0] blank;

    // Per-digit BCD increment/decrement with ripple carry/borrow; the final carry is the wrap.
    always_comb begin
        logic       carry;
        logic [3:0] d;
        bcd_step  = bcd_q;
        carry     = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            d = bcd_q[4*i +: 4];
            if (carry) begin
                if (bus.up) begin
                    if (d == 4'd9) bcd_step[4*i +: 4] = 4'd0;
                    else begin
                        bcd_step[4*i +: 4] = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) bcd_step[4*i +: 4] = 4'd9;
                    else begin
                        bcd_step[4*i +: 4] = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        step_wrap = carry;
    end

    // Load value with out-of-range digits clamped to 9.
    always_comb begin
        bcd_clamped = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            bcd_clamped[4*i +: 4] = (bus.load_bcd[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_bcd[4*i +: 4];
        end
    end

    // A digit above 0 is blanked when it and every higher digit are zero.
    always_comb begin
        logic higher_zero;
        blank       = '0;
        higher_zero = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            higher_zero = higher_zero & (bcd_q[4*i +: 4] == 4'd0);
            blank[i]    = BLANK_LZ && (i != 0) && higher_zero;
        end
    end

    // Next-state: clear > load > tick advance; scan runs regardless of count_en.
    always_comb begin
        pre_d       = pre_q;
        bcd_d       = bcd_q;
        scan_cnt_d  = scan_cnt_q;
        scan_idx_d  = scan_idx_q;
        digit_sel_d = digit_sel_q;
        segments_d  = segments_q;
        tick_d      = 1'b0;
        wrap_d      = 1'b0;

        if (bus.ena) begin
            if (bus.clear) begin
                pre_d = '0;
                bcd_d = '0;
            end else if (bus.load) begin
                pre_d = '0;
                bcd_d = bcd_clamped;
            end else if (bus.count_en) begin
                if (pre_q == PRE_LAST) begin
                    pre_d  = '0;
                    tick_d = 1'b1;
                    bcd_d  = bcd_step;
                    wrap_d = step_wrap;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end

            if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_d = '0;
                scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
            end else begin
                scan_cnt_d = scan_cnt_q + SW'(1);
            end

            digit_sel_d = '0;
            segments_d  = '0;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (scan_idx_d == IW'(i)) begin
                    digit_sel_d[i] = 1'b1;
                    segments_d     = blank[i] ? 7'h00 : seg7(bcd_q[4*i +: 4]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q       <= '0;
            bcd_q       <= '0;
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            digit_sel_q <= NUM_DIGITS'(1);
            segments_q  <= SEG_ZERO;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            bcd_q       <= bcd_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            digit_sel_q <= digit_sel_d;
            segments_q  <= segments_d;
            tick_q      <= tick_d;
            wrap_q      <= wrap_d;
        end
    end

    assign bus.bcd_out   = bcd_q;
    assign bus.digit_sel = digit_sel_q;
    assign bus.segments  = segments_q;
    assign bus.tick      = tick_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// Directed bench for seven_segment_counter_mux: 2 digits, 4-cycle tick, 2-cycle scan, blanking on.
module tb_seven_segment_counter_mux;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    seven_segment_counter_mux_if #(.NUM_DIGITS(2)) bus ();

    seven_segment_counter_mux #(
        .NUM_DIGITS(2),
        .TICK_COUNT(4),
        .SCAN_COUNT(2),
        .BLANK_LZ  (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input string tag, input int exp_cycles);
        int c;
        c = 0;
        do begin
            step();
            c++;
        end while (bus.tick !== 1'b1 && c < 20);
        check(tag, 32'(c), 32'(exp_cycles));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bcd"},  32'(bus.bcd_out),   32'h00);
        check({tag, "_sel"},  32'(bus.digit_sel), 32'h1);
        check({tag, "_seg"},  32'(bus.segments),  32'h3F);
        check({tag, "_tick"}, 32'(bus.tick),      32'h0);
        check({tag, "_wrap"}, 32'(bus.wrap),      32'h0);
    endtask

    initial begin
        logic [7:0] exp_bcd;
        logic [7:0] prev_bcd;
        logic [1:0] exp_sel;
        logic [6:0] exp_seg;

        n_vec = 0;
        n_err = 0;
        rst          = 1'b1;
        bus.ena      = 1'b1;
        bus.count_en = 1'b1;
        bus.up       = 1'b1;
        bus.clear    = 1'b0;
        bus.load     = 1'b0;
        bus.load_bcd = 8'h00;

        step();
        step();
        check_reset_vals("reset");
        rst = 1'b0;

        // Count up through a full rollover.
        for (int n = 1; n <= 100; n++) begin
            wait_tick("tick_period", 4);
            exp_bcd = {4'((n % 100) / 10), 4'(n % 10)};
            check("count_up_bcd", 32'(bus.bcd_out), 32'(exp_bcd));
            check("count_up_wrap", 32'(bus.wrap), (n == 100) ? 32'h1 : 32'h0);
        end
        step();
        check("wrap_one_cycle", 32'(bus.wrap), 32'h0);

        // Load zero then count down through the wrap.
        bus.load = 1'b1;
        bus.load_bcd = 8'h00;
        bus.up = 1'b0;
        step();
        bus.load = 1'b0;
        check("load0_bcd", 32'(bus.bcd_out), 32'h00);
        check("load0_tick", 32'(bus.tick), 32'h0);
        wait_tick("down_period", 4);
        check("down_wrap_bcd", 32'(bus.bcd_out), 32'h99);
        check("down_wrap_wrap", 32'(bus.wrap), 32'h1);
        wait_tick("down_period2", 4);
        check("down_bcd", 32'(bus.bcd_out), 32'h98);
        check("down_wrap0", 32'(bus.wrap), 32'h0);

        // Clear and load together on the prescaler terminal cycle.
        step();
        step();
        step();
        bus.clear = 1'b1;
        bus.load = 1'b1;
        bus.load_bcd = 8'h57;
        step();
        bus.clear = 1'b0;
        bus.load = 1'b0;
        check("clr_ld_bcd", 32'(bus.bcd_out), 32'h00);
        check("clr_ld_tick", 32'(bus.tick), 32'h0);
        check("clr_ld_wrap", 32'(bus.wrap), 32'h0);
        wait_tick("clr_presc_period", 4);
        check("clr_then_down_bcd", 32'(bus.bcd_out), 32'h99);

        // Clamped load, then pause.
        bus.load = 1'b1;
        bus.load_bcd = 8'hF3;
        step();
        bus.load = 1'b0;
        bus.count_en = 1'b0;
        check("clamp_bcd", 32'(bus.bcd_out), 32'h93);
        for (int i = 0; i < 20; i++) begin
            step();
            check("pause_tick", 32'(bus.tick), 32'h0);
        end
        check("pause_bcd", 32'(bus.bcd_out), 32'h93);

        // Scan and blanking from a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("scan_sel0", 32'(bus.digit_sel), 32'h1);
        prev_bcd = 8'h00;
        exp_bcd  = 8'h00;
        for (int k = 1; k <= 16; k++) begin
            bus.load = (k == 1 || k == 9);
            bus.load_bcd = (k == 1) ? 8'h05 : 8'h15;
            if (k == 1) exp_bcd = 8'h05;
            if (k == 9) exp_bcd = 8'h15;
            step();
            exp_sel = (((k / 2) % 2) == 1) ? 2'b10 : 2'b01;
            if (exp_sel == 2'b01) exp_seg = seg_ref(prev_bcd[3:0]);
            else exp_seg = (prev_bcd[7:4] == 4'd0) ? 7'h00 : seg_ref(prev_bcd[7:4]);
            check("scan_sel", 32'(bus.digit_sel), 32'(exp_sel));
            check("scan_seg", 32'(bus.segments), 32'(exp_seg));
            check("scan_bcd", 32'(bus.bcd_out), 32'(exp_bcd));
            prev_bcd = exp_bcd;
        end
        bus.load = 1'b0;

        // Asynchronous reset mid-period.
        bus.load = 1'b1;
        bus.load_bcd = 8'h42;
        bus.count_en = 1'b1;
        bus.up = 1'b1;
        step();
        bus.load = 1'b0;
        step();
        step();
        check("pre_rst_bcd", 32'(bus.bcd_out), 32'h42);
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_tick("post_rst_period", 4);
        check("post_rst_bcd", 32'(bus.bcd_out), 32'h01);

        // Enable low freezes everything.
        bus.ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("frz_bcd",  32'(bus.bcd_out),   32'h01);
            check("frz_sel",  32'(bus.digit_sel), 32'h1);
            check("frz_seg",  32'(bus.segments),  32'h3F);
            check("frz_tick", 32'(bus.tick),      32'h0);
            check("frz_wrap", 32'(bus.wrap),      32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seven_segment_counter_mux.md
Name: seven_segment_counter_mux

Overview:
Parametrised multi-digit BCD seconds counter driving a time-multiplexed common seven-segment display. A prescaler derives a count tick from the system clock. A NUM_DIGITS-wide BCD counter counts up or down with wrap and synchronous clear/load. A scan engine rotates one-hot digit selects and drives the shared segment bus through the existing seg7 decoder. It sits between the top-level I/O wrapper (ui_in/uo_out/uio_*) and the display pins.

Parameters:
NUM_DIGITS, 4, number of BCD digits and digit-select lines (1..8)
TICK_COUNT, 1000, clk cycles per count tick (>=2); prescaler width $clog2(TICK_COUNT)
SCAN_COUNT, 4, clk cycles each digit is displayed before the scan advances (>=1)
BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 never blanked); 0 = show all

Ports:
clk  input  1  system clock
rst  input  1  reset
ena  input  1  design enable; 0 freezes prescaler, counter and scan (outputs hold)
count_en  input  1  1 = prescaler runs and ticks advance the counter; 0 = pause (prescaler holds)
up  input  1  1 = count up, 0 = count down; sampled on the tick cycle
clear  input  1  synchronous clear of counter and prescaler
load  input  1  synchronous load of load_bcd into counter; prescaler cleared
load_bcd  input  4*NUM_DIGITS  load value, digit i at [4i+3:4i]
bcd_out  output  4*NUM_DIGITS  current counter value, registered
segments  output  7  segment pattern for the selected digit (seg7 encoding, active-high)
digit_sel  output  NUM_DIGITS  one-hot active-high digit enable
tick  output  1  one-cycle pulse on each prescaler terminal count
wrap  output  1  one-cycle pulse when the counter wraps (all-9 -> 0 up, 0 -> all-9 down)

Behaviour:
- Interface: one clock `clk`; reset is asynchronous and active-high (`rst`). All state is cleared on rst assertion without waiting for a clock edge. Release is synchronous to clk.
- Reset values: prescaler=0, bcd_out=0, scan index=0, scan counter=0, digit_sel=1 (digit 0), segments=seg7(0), tick=0, wrap=0.
- Priority, per cycle with ena=1: clear > load > tick advance.
- ena=0 overrides everything except rst: nothing changes and tick/wrap are 0.
- Prescaler: counts 0..TICK_COUNT-1 while count_en=1.
  - tick=1 in the cycle after the prescaler reaches TICK_COUNT-1, and the prescaler returns to 0 at that edge.
  - Tick period is exactly TICK_COUNT cycles.
- Counter: on a tick, add or subtract 1 in BCD.
  - Up: a digit at 9 rolls to 0 and carries into the next digit.
  - Down: a digit at 0 rolls to 9 and borrows from the next digit.
  - bcd_out updates at the same edge tick rises.
  - wrap pulses in the same cycle as tick only on full rollover.
- clear: bcd_out=0 and prescaler=0 at the next edge; no tick or wrap is generated that cycle.
- load: each loaded digit value above 9 is clamped to 9. Prescaler is set to 0. No tick or wrap that cycle.
- Scan engine:
  - The scan counter runs 0..SCAN_COUNT-1 independently of count_en.
  - At terminal count, the scan index advances i -> (i+1) mod NUM_DIGITS.
  - digit_sel and segments are registered together: they change on the same edge and reflect bcd_out of the previous cycle (1-cycle latency).
  - digit_sel is always exactly one-hot, never all-zero, including in the blank case.
- Blanking: with BLANK_LZ=1, digit i>0 shows segments=0 when it and all higher digits are 0.
- Mid-operation rst: returns immediately to the reset values; any pending tick is lost.
- Widths: the internal BCD arithmetic is per-digit 4-bit; no binary-to-BCD conversion.

Test Plan:
- NUM_DIGITS=2, TICK_COUNT=4, count_en=1, up=1 from reset:
  - tick every 4th cycle.
  - bcd_out goes 0x00,0x01,...,0x09,0x10.
  - After the 100th tick, bcd_out=0x00 with wrap=1 on that same cycle only.
- Load 0x00, up=0, one tick -> bcd_out=0x99 and wrap=1. Next tick -> 0x98 and wrap=0.
- Simultaneous clear and load with load_bcd=0x57 on a prescaler terminal cycle:
  - Next state is bcd_out=0x00, prescaler=0.
  - tick=0 and wrap=0.
- Load 0xF3 -> bcd_out=0x93 (upper digit clamped). Then count_en=0 for 20 cycles -> bcd_out stays 0x93 and no tick occurs.
- Scan with SCAN_COUNT=2, NUM_DIGITS=2, bcd_out=0x05, BLANK_LZ=1:
  - digit_sel alternates 01,01,10,10,...
  - segments=seg7(5) when digit_sel=01, and 0 when digit_sel=10.
  - Set bcd_out=0x15 -> digit 1 shows seg7(1).
- Assert rst asynchronously mid-count (between clk edges), with bcd_out=0x42 and the prescaler mid-period:
  - All outputs reach reset values before the next edge.
  - After release, the first tick arrives after exactly TICK_COUNT cycles.
  - ena=0 for 10 cycles -> all outputs frozen.
